// File: rtl/op_sequencer_pkg.sv
// Shared definitions for the op_sequencer slice: operation codes and FSM states.
package op_sequencer_pkg;

    typedef enum logic [1:0] {
        MODO_NOP = 2'b00,
        MODO_ADD = 2'b01,
        MODO_SUB = 2'b10,
        MODO_CLR = 2'b11
    } modo_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } state_e;

    function automatic logic is_nop(input logic [1:0] m);
        return m == MODO_NOP;
    endfunction

endpackage

// File: rtl/op_sequencer_if.sv
// Command and result valid/ready bus between a producer/consumer and op_sequencer.
interface op_sequencer_if #(
    parameter int unsigned W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_modo;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_q;
    logic         res_rco;
    logic [1:0]   res_modo;
    logic         busy;

    modport master (
        output cmd_valid, cmd_modo, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_q, res_rco, res_modo, busy
    );

    modport slave (
        input  cmd_valid, cmd_modo, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_q, res_rco, res_modo, busy
    );
endinterface

// File: rtl/op_fifo.sv
// Command FIFO: {modo, a, b} entries, registered head, no fall-through.
module op_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [2+2*W-1:0]  i_data,
    input  logic              i_pop,
    output logic [2+2*W-1:0]  o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned DW = 2 + 2 * W;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/op_sequencer.sv
// Streams queued add/sub/clear commands into the registered control unit as
// one-cycle enb pulses and holds each captured Q/RCO until the consumer takes it.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    op_sequencer_if.slave bus,
    output logic          enb,
    output logic [1:0]    modo,
    output logic [W-1:0]  A,
    output logic [W-1:0]  B,
    input  logic [W-1:0]  Q,
    input  logic          RCO
);
    localparam int unsigned DW = 2 + 2 * W;

    state_e       r_state;
    logic         r_enb;
    logic [1:0]   r_modo;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_res_valid;
    logic [W-1:0] r_res_q;
    logic         r_res_rco;
    logic [1:0]   r_res_modo;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_take;
    logic          w_issue;
    logic [DW-1:0] w_push_data;
    logic [DW-1:0] w_head;
    logic [1:0]    w_head_modo;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;

    assign w_push_data = {bus.cmd_modo, bus.cmd_a, bus.cmd_b};
    assign w_push      = bus.cmd_valid && !w_full;
    assign {w_head_modo, w_head_a, w_head_b} = w_head;

    // IDLE, or HOLD whose result is being taken this edge, may consume the head.
    assign w_take  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.res_ready);
    assign w_pop   = w_take && !w_empty;
    assign w_issue = w_pop && !is_nop(w_head_modo);

    op_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_enb       <= 1'b0;
            r_modo      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_valid <= 1'b0;
            r_res_q     <= '0;
            r_res_rco   <= 1'b0;
            r_res_modo  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_take) begin
                        r_res_valid <= 1'b0;
                        if (w_issue) begin
                            r_enb   <= 1'b1;
                            r_modo  <= w_head_modo;
                            r_a     <= w_head_a;
                            r_b     <= w_head_b;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_enb   <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_res_q     <= Q;
                    r_res_rco   <= RCO;
                    r_res_modo  <= r_modo;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign enb  = r_enb;
    assign modo = r_modo;
    assign A    = r_a;
    assign B    = r_b;

    assign bus.cmd_ready = !w_full;
    assign bus.res_valid = r_res_valid;
    assign bus.res_q     = r_res_q;
    assign bus.res_rco   = r_res_rco;
    assign bus.res_modo  = r_res_modo;
    assign bus.busy      = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer driving a behavioural registered add/sub unit.
module tb_op_sequencer;
    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          MODV  = 1 << W;

    typedef struct packed {
        logic [1:0]   modo;
        logic         rco;
        logic [W-1:0] q;
    } res_t;

    localparam logic [20:0] RST_OUTS = {1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1};

    logic         clk = 1'b0;
    logic         reset;
    logic         enb;
    logic [1:0]   modo;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q   = '0;
    logic         RCO = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   enb_total = 0;
    int   enb_cyc[$];
    res_t exp_q[$];

    op_sequencer_if #(.W(W)) bus ();

    op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .enb   (enb),
        .modo  (modo),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .RCO   (RCO)
    );

    always #5 clk = ~clk;

    // Control unit: samples enb/modo/A/B at the edge, result registered; not reset.
    always @(posedge clk) begin
        if (enb === 1'b1) begin
            case (modo)
                2'b01:   {RCO, Q} <= {1'b0, A} + {1'b0, B};
                2'b10:   {RCO, Q} <= {1'b0, A} - {1'b0, B};
                2'b11:   {RCO, Q} <= '0;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (enb === 1'b1) begin
            enb_total++;
            enb_cyc.push_back(cyc);
        end
    end

    function automatic res_t ref_op(input logic [1:0] m, input int a, input int b);
        res_t r;
        int   s;
        r.modo = m;
        r.rco  = 1'b0;
        r.q    = '0;
        if (m == 2'b01) begin
            s     = a + b;
            r.rco = (s >= MODV);
            r.q   = W'(s % MODV);
        end else if (m == 2'b10) begin
            s     = a - b;
            r.rco = (s < 0);
            if (s < 0) s = s + MODV;
            r.q   = W'(s);
        end
        return r;
    endfunction

    function automatic logic [20:0] outs();
        return {enb, modo, A, B, bus.res_valid, bus.res_q, bus.res_rco, bus.res_modo, bus.busy, bus.cmd_ready};
    endfunction

    function automatic res_t res_now();
        return {bus.res_modo, bus.res_rco, bus.res_q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_modo  = m;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (outs() !== RST_OUTS) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", outs(), RST_OUTS);
        end
        tick();
        tick();
        n_tests++;
        if (outs() !== RST_OUTS) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", outs(), RST_OUTS);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (outs() !== RST_OUTS) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", outs(), RST_OUTS);
        end
    endtask

    task automatic test_single();
        res_t e;
        e = ref_op(2'b01, 7, 5);
        bus.res_ready = 1'b1;
        drive_cmd(2'b01, 4'd7, 4'd5);
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (bus.res_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_latency edge t+%0d: res_valid got %b expected %b", k, bus.res_valid, (k == 3));
            end
            if (k == 1) begin
                n_tests++;
                if ({enb, modo, A, B} !== {1'b1, 2'b01, 4'd7, 4'd5}) begin
                    n_fail++;
                    $display("FAIL single_issue: got %h expected %h", {enb, modo, A, B}, {1'b1, 2'b01, 4'd7, 4'd5});
                end
            end
            if (k == 2) begin
                n_tests++;
                if (enb !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_enb_pulse: got %b expected 0", enb);
                end
            end
        end
        n_tests++;
        if (res_now() !== e) begin
            n_fail++;
            $display("FAIL single_result: got %h expected %h", res_now(), e);
        end
        tick();
        n_tests++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_drain: valid/busy got %b expected 00", {bus.res_valid, bus.busy});
        end
    endtask

    task automatic test_carry();
        logic [1:0]   cm [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
        logic [W-1:0] ca [5] = '{4'd9, 4'd3, 4'd15, 4'd5, 4'd0};
        logic [W-1:0] cb [5] = '{4'd8, 4'd5, 4'd1, 4'd5, 4'd15};
        res_t e;
        int   c;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = ref_op(cm[i], int'(ca[i]), int'(cb[i]));
            drive_cmd(cm[i], ca[i], cb[i]);
            tick();
            bus.cmd_valid = 1'b0;
            c = 0;
            while (bus.res_valid !== 1'b1 && c < 10) begin
                tick();
                c++;
            end
            n_tests++;
            if (bus.res_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL carry_timeout case %0d: res_valid got %b expected 1", i, bus.res_valid);
            end else if (res_now() !== e) begin
                n_fail++;
                $display("FAIL carry_result case %0d: got %h expected %h", i, res_now(), e);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]   cm [DEPTH+2];
        logic [W-1:0] ca [DEPTH+2];
        logic [W-1:0] cb [DEPTH+2];
        int   acc;
        int   got;
        int   extra;
        logic will;
        res_t e;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cm[i] = 2'($urandom_range(1, 2));
            ca[i] = W'($urandom_range(0, MODV - 1));
            cb[i] = W'($urandom_range(0, MODV - 1));
        end
        exp_q.delete();
        bus.res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (acc < DEPTH + 2) drive_cmd(cm[acc], ca[acc], cb[acc]);
            will = bus.cmd_ready;
            tick();
            if (will) begin
                exp_q.push_back(ref_op(cm[acc], int'(ca[acc]), int'(cb[acc])));
                acc++;
            end
        end
        n_tests++;
        if (acc != DEPTH + 1) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH + 1);
        end
        n_tests++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_cmd_ready: got %b expected 0", bus.cmd_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++;
            if (exp_q.size() == 0 || bus.res_valid !== 1'b1 || res_now() !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid %b res %h", c, bus.res_valid, res_now());
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < DEPTH + 1; c++) begin
            if (bus.res_valid === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                n_tests++;
                if (res_now() !== e) begin
                    n_fail++;
                    $display("FAIL bp_order result %0d: got %h expected %h", got, res_now(), e);
                end
                got++;
            end
            tick();
        end
        n_tests++;
        if (got != DEPTH + 1) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected %0d", got, DEPTH + 1);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.res_valid === 1'b1) extra++;
            tick();
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL bp_extra: got %0d extra result cycles expected 0", extra);
        end
    endtask

    task automatic test_nop_clear();
        logic [1:0] cm [3] = '{2'b00, 2'b11, 2'b01};
        res_t ex [2];
        int   e0;
        int   got;
        ex[0] = ref_op(2'b11, 0, 0);
        ex[1] = ref_op(2'b01, 1, 1);
        e0 = enb_total;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(cm[i], 4'd1, 4'd1);
            n_tests++;
            if (bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL nop_cmd_ready %0d: got %b expected 1", i, bus.cmd_ready);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.res_valid === 1'b1) begin
                if (got < 2) begin
                    n_tests++;
                    if (res_now() !== ex[got]) begin
                        n_fail++;
                        $display("FAIL nop_result %0d: got %h expected %h", got, res_now(), ex[got]);
                    end
                end
                got++;
            end
            tick();
        end
        n_tests++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL nop_count: got %0d results expected 2", got);
        end
        n_tests++;
        if (enb_total - e0 != 2) begin
            n_fail++;
            $display("FAIL nop_enb_pulses: got %0d expected 2", enb_total - e0);
        end
    endtask

    task automatic test_reset_midop();
        int   c;
        int   seen;
        res_t e;
        bus.res_ready = 1'b1;
        drive_cmd(2'b01, 4'd6, 4'd7);
        tick();
        bus.cmd_valid = 1'b0;
        c = 0;
        while (enb !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        n_tests++;
        if (enb !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_issue_timeout: enb got %b expected 1", enb);
        end
        tick();
        n_tests++;
        if ({bus.busy, bus.res_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_in_wait: busy/valid got %b expected 10", {bus.busy, bus.res_valid});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (outs() !== RST_OUTS) begin
            n_fail++;
            $display("FAIL midrst_async: got %h expected %h", outs(), RST_OUTS);
        end
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.res_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_result: got %0d result cycles expected 0", seen);
        end
        e = ref_op(2'b01, 2, 3);
        drive_cmd(2'b01, 4'd2, 4'd3);
        tick();
        bus.cmd_valid = 1'b0;
        c = 0;
        while (bus.res_valid !== 1'b1 && c < 10) begin
            tick();
            c++;
        end
        n_tests++;
        if (bus.res_valid !== 1'b1 || res_now() !== e) begin
            n_fail++;
            $display("FAIL midrst_post_add: valid %b got %h expected %h", bus.res_valid, res_now(), e);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [1:0]   cm [16];
        logic [W-1:0] ca [16];
        logic [W-1:0] cb [16];
        int   idx;
        int   got;
        logic acc;
        res_t e;
        for (int i = 0; i < 16; i++) begin
            cm[i] = 2'($urandom_range(1, 2));
            ca[i] = W'($urandom_range(0, MODV - 1));
            cb[i] = W'($urandom_range(0, MODV - 1));
        end
        exp_q.delete();
        enb_cyc.delete();
        bus.res_ready = 1'b1;
        idx = 0;
        got = 0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            if (idx < 16) drive_cmd(cm[idx], ca[idx], cb[idx]);
            else bus.cmd_valid = 1'b0;
            acc = (idx < 16) && bus.cmd_ready;
            if (bus.res_valid === 1'b1) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                n_tests++;
                if (res_now() !== e) begin
                    n_fail++;
                    $display("FAIL stream_result %0d: got %h expected %h", got, res_now(), e);
                end
                got++;
            end
            tick();
            if (acc) begin
                exp_q.push_back(ref_op(cm[idx], int'(ca[idx]), int'(cb[idx])));
                idx++;
            end
        end
        bus.cmd_valid = 1'b0;
        n_tests++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 16", got);
        end
        n_tests++;
        if (enb_cyc.size() != 16) begin
            n_fail++;
            $display("FAIL stream_enb_count: got %0d expected 16", enb_cyc.size());
        end
        for (int i = 1; i < enb_cyc.size(); i++) begin
            n_tests++;
            if (enb_cyc[i] - enb_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL stream_spacing op %0d: got %0d cycles expected 3", i, enb_cyc[i] - enb_cyc[i-1]);
            end
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_modo  = 2'b00;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_backpressure();
        test_nop_clear();
        test_reset_midop();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
